regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (write_reg / write_enable / write_data) between NUM_REQ writeback requesters, e.g. ALU result and memory load result.
- Arbitration is round-robin with a valid/ready handshake per requester.
- One registered output stage drives the register file.
- Also exports a pending-write mask so hazard/stall logic can see destinations not yet committed.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and the writeback request record
// used by the writeback stages and the register-file write arbiter.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_idx;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // r0 is hardwired to zero, so writes aimed at it must never reach the array
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] idx);
        return (idx == ZERO_REG);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr (mod N) wins.
// grant is one-hot and gated by enable; winner/found describe the pick regardless.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner,
    output logic          found
);

    int idx_s;

    // Scan upward from ptr with wrap and keep the first valid requester
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx_s  = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = int'(ptr) + k;
            idx_s = (idx_s >= N) ? (idx_s - N) : idx_s;
            if (!found && req[idx_s]) begin
                found  = 1'b1;
                winner = PW'(idx_s);
            end else begin
                found  = found;
                winner = winner;
            end
        end
        if (found && enable) begin
            grant[winner] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file's single write port between NUM_REQ
// writeback requesters, with one registered output stage and a pending-write mask.
module regfile_write_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             hold,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_reg,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [ADDR_WIDTH-1:0]            write_reg,
    output logic                             write_enable,
    output logic [DATA_WIDTH-1:0]            write_data,
    output logic [(2**ADDR_WIDTH)-1:0]       pending_mask
);

    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG = 2**ADDR_WIDTH;

    logic [PW-1:0]         rr_ptr_r;
    logic [PW-1:0]         winner_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic                  found_s;
    logic                  grant_en_s;
    logic                  accept_s;
    wb_req_t               sel_s;
    logic [NREG-1:0]       pending_s;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] wr_reg_r;
    logic [DATA_WIDTH-1:0] wr_data_r;

    // Grants are suppressed during a stall and while reset is asserted
    assign grant_en_s = ~hold & reset;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr_r),
        .enable (grant_en_s),
        .grant  (grant_s),
        .winner (winner_s),
        .found  (found_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = found_s & (|(grant_s & req_valid));

    // Route the winning requester's destination and data toward the output stage
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == PW'(i)) begin
                sel_s.reg_idx = req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_s.data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Destinations requested now or sitting in the output stage; r0 never pends
    always_comb begin
        pending_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                pending_s[req_reg[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
        if (we_r) begin
            pending_s[wr_reg_r] = 1'b1;
        end else begin
            pending_s = pending_s;
        end
        pending_s[0] = 1'b0;
    end

    assign pending_mask = pending_s;

    // Output stage and round-robin pointer; accepted r0 writes load with enable low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r      <= 1'b0;
            wr_reg_r  <= '0;
            wr_data_r <= '0;
            rr_ptr_r  <= '0;
        end else if (accept_s) begin
            we_r      <= ~is_zero_reg(sel_s.reg_idx);
            wr_reg_r  <= sel_s.reg_idx;
            wr_data_r <= sel_s.data;
            rr_ptr_r  <= (winner_s == PW'(NUM_REQ-1)) ? '0 : (winner_s + PW'(1));
        end else begin
            we_r      <= 1'b0;
            wr_reg_r  <= wr_reg_r;
            wr_data_r <= wr_data_r;
            rr_ptr_r  <= rr_ptr_r;
        end
    end

    assign write_enable = we_r;
    assign write_reg    = wr_reg_r;
    assign write_data   = wr_data_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table-driven bench for regfile_write_arbiter with a behavioural register
// file fed by the write port, plus hand-written reset and hold sequences.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        hold;
    logic [1:0]  req_valid;
    logic [9:0]  req_reg;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [4:0]  write_reg;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] pending_mask;

    logic [31:0] rf [32];
    int checks;
    int failures;
    int vec_idx;

    regfile_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_reg      (req_reg),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_reg    (write_reg),
        .write_enable (write_enable),
        .write_data   (write_data),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    end

    // Register file model: commits whatever the write port presents at the edge
    always @(posedge clk) begin
        if (reset && write_enable && (write_reg != 5'd0)) rf[write_reg] <= write_data;
    end

    typedef struct {
        logic [1:0]  valid;
        logic        hold;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic [1:0]  ready;
        logic [31:0] mask;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [31:0] bm(input int a, input int b);
        logic [31:0] m;
        m = 32'd0;
        if (a > 0) m[a] = 1'b1;
        if (b > 0) m[b] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(input logic [1:0] v, input logic h,
                                input logic [4:0] r0, input logic [31:0] d0,
                                input logic [4:0] r1, input logic [31:0] d1,
                                input logic [1:0] rdy, input logic [31:0] m,
                                input logic we, input logic [4:0] wr, input logic [31:0] wd);
        vec_t t;
        t.valid = v; t.hold = h; t.r0 = r0; t.d0 = d0; t.r1 = r1; t.d1 = d1;
        t.ready = rdy; t.mask = m; t.we = we; t.wreg = wr; t.wdata = wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, vec_idx, act, exp);
        end
    endtask

    initial begin
        checks = 0; failures = 0; vec_idx = -1;
        reset = 1'b0; hold = 1'b0;
        req_valid = 2'b11; req_reg = {5'd2, 5'd1}; req_data = {32'h22, 32'h11};

        //       valid  hold r0     d0             r1     d1             ready  mask        we    wreg   wdata
        vecs[0]  = mk(2'b01, 1'b0, 5'd8, 32'h12345678, 5'd0, 32'h0,        2'b01, bm(8,0),    1'b1, 5'd8, 32'h12345678);
        vecs[1]  = mk(2'b00, 1'b0, 5'd8, 32'h12345678, 5'd0, 32'h0,        2'b00, bm(8,0),    1'b0, 5'd8, 32'h12345678);
        vecs[2]  = mk(2'b10, 1'b0, 5'd8, 32'h0,        5'd0, 32'hFFFFFFFF, 2'b10, 32'h0,      1'b0, 5'd0, 32'hFFFFFFFF);
        vecs[3]  = mk(2'b11, 1'b0, 5'd3, 32'hA,        5'd4, 32'hB,        2'b01, bm(3,4),    1'b1, 5'd3, 32'hA);
        vecs[4]  = mk(2'b11, 1'b0, 5'd3, 32'hA,        5'd4, 32'hB,        2'b10, bm(3,4),    1'b1, 5'd4, 32'hB);
        vecs[5]  = mk(2'b11, 1'b0, 5'd3, 32'hA,        5'd4, 32'hB,        2'b01, bm(3,4),    1'b1, 5'd3, 32'hA);
        vecs[6]  = mk(2'b11, 1'b0, 5'd3, 32'hA,        5'd4, 32'hB,        2'b10, bm(3,4),    1'b1, 5'd4, 32'hB);
        vecs[7]  = mk(2'b01, 1'b0, 5'd3, 32'hA,        5'd4, 32'hB,        2'b01, bm(3,4),    1'b1, 5'd3, 32'hA);
        vecs[8]  = mk(2'b11, 1'b1, 5'd3, 32'hA,        5'd4, 32'hB,        2'b00, bm(3,4),    1'b0, 5'd3, 32'hA);
        vecs[9]  = mk(2'b11, 1'b1, 5'd3, 32'hA,        5'd4, 32'hB,        2'b00, bm(3,4),    1'b0, 5'd3, 32'hA);
        vecs[10] = mk(2'b11, 1'b1, 5'd3, 32'hA,        5'd4, 32'hB,        2'b00, bm(3,4),    1'b0, 5'd3, 32'hA);
        vecs[11] = mk(2'b11, 1'b0, 5'd3, 32'hA,        5'd4, 32'hB,        2'b10, bm(3,4),    1'b1, 5'd4, 32'hB);
        vecs[12] = mk(2'b00, 1'b0, 5'd3, 32'hA,        5'd4, 32'hB,        2'b00, bm(4,0),    1'b0, 5'd4, 32'hB);
        vecs[13] = mk(2'b11, 1'b0, 5'd6, 32'h66,       5'd9, 32'h99,       2'b01, bm(6,9),    1'b1, 5'd6, 32'h66);
        vecs[14] = mk(2'b10, 1'b0, 5'd6, 32'h66,       5'd9, 32'h99,       2'b10, bm(6,9),    1'b1, 5'd9, 32'h99);
        vecs[15] = mk(2'b00, 1'b0, 5'd6, 32'h66,       5'd9, 32'h99,       2'b00, bm(9,0),    1'b0, 5'd9, 32'h99);
        vecs[16] = mk(2'b00, 1'b0, 5'd6, 32'h66,       5'd9, 32'h99,       2'b00, 32'h0,      1'b0, 5'd9, 32'h99);
        vecs[17] = mk(2'b11, 1'b0, 5'd7, 32'h70,       5'd7, 32'h71,       2'b01, bm(7,0),    1'b1, 5'd7, 32'h70);
        vecs[18] = mk(2'b10, 1'b0, 5'd7, 32'h70,       5'd7, 32'h71,       2'b10, bm(7,0),    1'b1, 5'd7, 32'h71);
        vecs[19] = mk(2'b00, 1'b0, 5'd7, 32'h70,       5'd7, 32'h71,       2'b00, bm(7,0),    1'b0, 5'd7, 32'h71);

        // Reset state: nothing granted even with both requesters valid
        #12;
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_we",    64'(write_enable), 64'd0);
        chk("reset_wreg",  64'(write_reg), 64'd0);
        chk("reset_wdata", 64'(write_data), 64'd0);
        req_valid = 2'b00;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            vec_idx   = i;
            req_valid = vecs[i].valid;
            hold      = vecs[i].hold;
            req_reg   = {vecs[i].r1, vecs[i].r0};
            req_data  = {vecs[i].d1, vecs[i].d0};
            #1;
            chk("req_ready",    64'(req_ready), 64'(vecs[i].ready));
            chk("pending_mask", 64'(pending_mask), 64'(vecs[i].mask));
            @(posedge clk); #1;
            chk("write_enable", 64'(write_enable), 64'(vecs[i].we));
            chk("write_reg",    64'(write_reg), 64'(vecs[i].wreg));
            chk("write_data",   64'(write_data), 64'(vecs[i].wdata));
        end

        // Architectural state after the table: r0 untouched, same-destination last grant wins
        vec_idx = 100;
        chk("rf_r8", 64'(rf[8]), 64'h12345678);
        chk("rf_r0", 64'(rf[0]), 64'd0);
        chk("rf_r3", 64'(rf[3]), 64'hA);
        chk("rf_r4", 64'(rf[4]), 64'hB);
        chk("rf_r6", 64'(rf[6]), 64'h66);
        chk("rf_r9", 64'(rf[9]), 64'h99);
        chk("rf_r7", 64'(rf[7]), 64'h71);

        // Accept a write to r5 (pointer moves to 1), then reset mid-cycle before commit
        vec_idx = 101;
        req_valid = 2'b01; req_reg = {5'd0, 5'd5}; req_data = {32'h0, 32'h55};
        #1;
        chk("r5_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        chk("r5_we", 64'(write_enable), 64'd1);
        req_valid = 2'b11; req_reg = {5'd2, 5'd1}; req_data = {32'h22, 32'h11};
        #2 reset = 1'b0;
        #1;
        chk("async_we",    64'(write_enable), 64'd0);
        chk("async_wreg",  64'(write_reg), 64'd0);
        chk("async_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("rf_r5_kept", 64'(rf[5]), 64'd0);
        req_valid = 2'b00;
        @(negedge clk); reset = 1'b1;
        #1;
        chk("post_rst_ready_idle", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_we", 64'(write_enable), 64'd0);
        req_valid = 2'b11;
        #1;
        chk("post_rst_ptr0", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        chk("post_rst_wreg", 64'(write_reg), 64'd1);
        chk("post_rst_wdata", 64'(write_data), 64'h11);
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("rf_r1", 64'(rf[1]), 64'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
